// File: rtl/ps_slot_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : ps_slot_scheduler_if
// Purpose  : Requester/serializer bundle shared by the slot scheduler.
// Revision : 1.0 - initial release
// ============================================================================
interface ps_slot_scheduler_if #(
    parameter int NUM_REQ = 4
);
    localparam int c_grant_w = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ*8-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ack;
    logic [7:0]           data_in_PS;
    logic                 valid_in_PS;
    logic [c_grant_w-1:0] grant_id;
    logic                 slot_start;
    logic                 trained;

    // Requester side drives the byte offers and observes the slot outputs.
    modport master (
        output req_valid, req_data,
        input  req_ack, data_in_PS, valid_in_PS, grant_id, slot_start, trained
    );

    modport slave (
        input  req_valid, req_data,
        output req_ack, data_in_PS, valid_in_PS, grant_id, slot_start, trained
    );
endinterface
`default_nettype wire

// File: rtl/ps_slot_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : ps_slot_scheduler
// Purpose  : Round-robin slot scheduler feeding one parallel-to-serial unit.
// Revision : 1.0 - initial release
// ============================================================================
module ps_slot_scheduler #(
    parameter int         NUM_REQ      = 4,
    parameter int         BITS_PER_SYM = 8,
    parameter int         TRAIN_SYMS   = 4,
    parameter logic [7:0] COM_SYM      = 8'hBC
) (
    input  wire logic          clk_PS,
    input  wire logic          reset,
    ps_slot_scheduler_if.slave bus
);

    localparam int c_grant_w = $clog2(NUM_REQ);
    localparam int c_cnt_w   = (BITS_PER_SYM > 1) ? $clog2(BITS_PER_SYM) : 1;
    localparam int c_train_w = $clog2(TRAIN_SYMS + 1);

    localparam logic [c_cnt_w-1:0]   c_last_bit   = c_cnt_w'(BITS_PER_SYM - 1);
    localparam logic [c_train_w-1:0] c_last_train = c_train_w'(TRAIN_SYMS - 1);
    localparam logic [c_grant_w-1:0] c_last_req   = c_grant_w'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0]   c_ack_base   = NUM_REQ'(1);

    typedef enum logic [0:0] {
        ST_TRAIN = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_cnt_w-1:0]   r_bit_cnt;
    logic [c_train_w-1:0] r_train_cnt;
    logic [c_train_w-1:0] w_train_nxt;
    logic [c_grant_w-1:0] r_last_grant;
    logic [c_grant_w-1:0] w_last_nxt;
    logic [7:0]           r_data;
    logic [7:0]           w_data_nxt;
    logic                 r_valid;
    logic                 w_valid_nxt;
    logic [c_grant_w-1:0] r_grant;
    logic [c_grant_w-1:0] w_grant_nxt;
    logic [NUM_REQ-1:0]   r_ack;
    logic [NUM_REQ-1:0]   w_ack_nxt;
    logic                 r_slot_start;
    logic                 w_slot_start_nxt;
    logic                 r_trained;
    logic                 w_trained_nxt;

    logic                 w_boundary;
    logic                 w_arb;
    logic                 w_win_found;
    logic [c_grant_w-1:0] w_win_idx;
    logic [7:0]           w_win_byte;

    assign w_boundary = (r_bit_cnt == c_last_bit);

    // Rotating-priority search starting just after the previous winner.
    always_comb begin
        logic [c_grant_w-1:0] cand;
        cand        = '0;
        w_win_found = 1'b0;
        w_win_idx   = '0;
        w_win_byte  = COM_SYM;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = r_last_grant + c_grant_w'(off);
            if (!w_win_found && bus.req_valid[cand]) begin
                w_win_found = 1'b1;
                w_win_idx   = cand;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win_idx == c_grant_w'(i)) begin
                w_win_byte = bus.req_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_train_nxt      = r_train_cnt;
        w_last_nxt       = r_last_grant;
        w_data_nxt       = r_data;
        w_valid_nxt      = r_valid;
        w_grant_nxt      = r_grant;
        w_ack_nxt        = '0;
        w_slot_start_nxt = 1'b0;
        w_trained_nxt    = r_trained;
        w_arb            = 1'b0;

        if (w_boundary) begin
            w_slot_start_nxt = 1'b1;
            unique case (r_state)
                ST_TRAIN: begin
                    w_data_nxt  = COM_SYM;
                    w_valid_nxt = 1'b0;
                    // The last training boundary also opens the first data slot.
                    if (r_train_cnt == c_last_train) begin
                        w_state_nxt   = ST_RUN;
                        w_trained_nxt = 1'b1;
                        w_arb         = 1'b1;
                    end else begin
                        w_train_nxt = r_train_cnt + c_train_w'(1);
                    end
                end
                ST_RUN: begin
                    w_arb = 1'b1;
                end
                default: begin
                    w_state_nxt = ST_TRAIN;
                end
            endcase
        end

        if (w_arb) begin
            if (w_win_found) begin
                w_data_nxt  = w_win_byte;
                w_valid_nxt = 1'b1;
                w_grant_nxt = w_win_idx;
                w_last_nxt  = w_win_idx;
                w_ack_nxt   = c_ack_base << w_win_idx;
            end else begin
                w_data_nxt  = COM_SYM;
                w_valid_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_PS or posedge reset) begin
        if (reset) begin
            r_state      <= ST_TRAIN;
            r_bit_cnt    <= '0;
            r_train_cnt  <= '0;
            r_last_grant <= c_last_req;
            r_data       <= COM_SYM;
            r_valid      <= 1'b0;
            r_grant      <= '0;
            r_ack        <= '0;
            r_slot_start <= 1'b0;
            r_trained    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_bit_cnt    <= w_boundary ? '0 : r_bit_cnt + c_cnt_w'(1);
            r_train_cnt  <= w_train_nxt;
            r_last_grant <= w_last_nxt;
            r_data       <= w_data_nxt;
            r_valid      <= w_valid_nxt;
            r_grant      <= w_grant_nxt;
            r_ack        <= w_ack_nxt;
            r_slot_start <= w_slot_start_nxt;
            r_trained    <= w_trained_nxt;
        end
    end

    assign bus.req_ack     = r_ack;
    assign bus.data_in_PS  = r_data;
    assign bus.valid_in_PS = r_valid;
    assign bus.grant_id    = r_grant;
    assign bus.slot_start  = r_slot_start;
    assign bus.trained     = r_trained;

endmodule
`default_nettype wire

// File: doc/ps_slot_scheduler.md
Name: ps_slot_scheduler

Overview:
- Round-robin scheduler that shares one parallel-to-serial converter (module_PS) between NUM_REQ byte-stream requesters.
- Runs on the serial bit clock and divides it into symbol slots of BITS_PER_SYM cycles.
- After reset it sends TRAIN_SYMS idle/COM slots, then grants one requester per slot. It drives data_in_PS and valid_in_PS directly.

Parameters:
- NUM_REQ, 4, number of requesters (power of 2, ≥2).
- BITS_PER_SYM, 8, clk_PS cycles per symbol slot; equals the serializer byte width.
- TRAIN_SYMS, 4, COM slots sent after reset before arbitration starts (≥1).
- COM_SYM, 8'hBC, byte driven on data_in_PS when no data is valid.

Ports:
- clk_PS  in  1  serial bit clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- req_valid  in  NUM_REQ  requester i holds a byte.
- req_data  in  NUM_REQ*8  packed bytes; requester i at [8i+7:8i].
- req_ack  out  NUM_REQ  one-hot, one-cycle pulse: byte of requester i consumed.
- data_in_PS  out  8  byte to serializer; registered.
- valid_in_PS  out  1  data_in_PS carries requester data; registered.
- grant_id  out  log2(NUM_REQ)  index of requester owning the current slot.
- slot_start  out  1  one-cycle pulse in the first cycle of each new slot.
- trained  out  1  high once training is complete.

Behaviour:
- Reset values:
  - data_in_PS=COM_SYM, valid_in_PS=0, req_ack=0, grant_id=0, slot_start=0, trained=0.
  - Internal: bit_cnt=0, train_cnt=0, last_grant=NUM_REQ-1 (requester 0 has first priority), state=TRAIN.
- Timing reference: cycle k = k-th rising edge after reset deasserts; cycle 0 = before the first edge. bit_cnt = k mod BITS_PER_SYM.
- Slot timing:
  - Slot boundary = the edge taken while bit_cnt==BITS_PER_SYM-1.
  - Slot-output registers change only at boundaries, so they are stable for exactly BITS_PER_SYM cycles.
  - slot_start=1 in cycles where bit_cnt==0, except cycle 0.
- FSM TRAIN:
  - Cycle-0 slot counts as training slot 0. Every slot: valid_in_PS=0, data_in_PS=COM_SYM, no ack.
  - At a boundary with train_cnt==TRAIN_SYMS-1: go to RUN, set trained=1, and arbitrate at that same boundary.
  - First data slot occupies cycles TRAIN_SYMS*BITS_PER_SYM onward (cycle 32 by default).
  - Otherwise increment train_cnt at each boundary.
- FSM RUN, arbitration at each boundary:
  - Sample req_valid at the boundary. Search order: last_grant+1, +2, … modulo NUM_REQ.
  - Winner w found: data_in_PS=req_data[w], valid_in_PS=1, grant_id=w, last_grant=w, req_ack[w]=1 for the first cycle of the new slot only.
  - No request: valid_in_PS=0, data_in_PS=COM_SYM, grant_id and last_grant unchanged, req_ack=0.
  - RUN has no exit except reset.
- Requester contract:
  - Hold req_valid and req_data stable until ack.
  - On ack, the requester may present its next byte in the same cycle; it competes at the next boundary, behind other pending requesters.
  - Changes between boundaries are ignored.
- Fairness: with all requesters valid, grants cycle 0,1,…,NUM_REQ-1,0,…; no requester waits more than NUM_REQ-1 slots.
- Reset mid-operation:
  - All outputs go to reset values asynchronously.
  - The in-flight slot byte is abandoned; its ack has already been given, so no re-send.
  - Training restarts fully.

Test Plan:
1. Reset and training: reset high 3 cycles, req_valid=4'b1111, bytes 11/22/33/44.
   - Cycles 0–31: trained=0, valid_in_PS=0, data_in_PS=8'hBC, req_ack=0.
   - Cycle 32: trained=1, slot_start=1, grant_id=0, data_in_PS=8'h11, req_ack=4'b0001.
2. Full round robin: all valid, bytes held constant.
   - Slots starting at cycles 32/40/48/56/64 carry 11,22,33,44,11.
   - Acks are 0001, 0010, 0100, 1000, 0001, each exactly 1 cycle long.
3. Idle: req_valid=0 in RUN after grant 2.
   - valid_in_PS=0, data_in_PS=8'hBC, grant_id stays 2, slot_start still pulses every 8 cycles.
4. Pointer rotation: after grant 2, req1 and req3 both valid at the same boundary.
   - Grant 3 first, then 1 at the next boundary. A req_valid pulse in bit_cnt 2–5 only is ignored.
5. Async reset mid-slot: assert reset at bit_cnt=4 of a slot owned by requester 1.
   - Outputs reach reset values before the next edge.
   - After release, 32 COM cycles again before any grant.
6. End-to-end with module_PS (bench inverts reset for reset_L), bytes 8'hA5 then 8'h3C from requester 0.
   - Serial stream, sampled and reassembled, yields BC×4, A5, 3C, then BC.
